// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator keypad types and the button decode.
//   active_button_t : encoded single button (B_NONE = no button).
//   buttons_t       : one-hot drive vector, one bit per physical button.
//   active_button_to_buttons() : encoded button -> one-hot drive.
package calc_pkg;

   typedef enum logic [4:0] {
      B_NONE   = 5'd0,
      B_NUM_0  = 5'd1,
      B_NUM_1  = 5'd2,
      B_NUM_2  = 5'd3,
      B_NUM_3  = 5'd4,
      B_NUM_4  = 5'd5,
      B_NUM_5  = 5'd6,
      B_NUM_6  = 5'd7,
      B_NUM_7  = 5'd8,
      B_NUM_8  = 5'd9,
      B_NUM_9  = 5'd10,
      B_OP_ADD = 5'd11,
      B_OP_SUB = 5'd12,
      B_OP_MUL = 5'd13,
      B_OP_DIV = 5'd14,
      B_EQUALS = 5'd15,
      B_CLEAR  = 5'd16
   } active_button_t;

   typedef struct packed {
      logic clear;
      logic equals;
      logic op_div;
      logic op_mul;
      logic op_sub;
      logic op_add;
      logic num_9;
      logic num_8;
      logic num_7;
      logic num_6;
      logic num_5;
      logic num_4;
      logic num_3;
      logic num_2;
      logic num_1;
      logic num_0;
   } buttons_t;

   // B_NONE and any unlisted encoding decode to all-released.
   function automatic buttons_t active_button_to_buttons(input active_button_t b);
      buttons_t r;
      r = '0;
      case (b)
         B_NUM_0:  r.num_0  = 1'b1;
         B_NUM_1:  r.num_1  = 1'b1;
         B_NUM_2:  r.num_2  = 1'b1;
         B_NUM_3:  r.num_3  = 1'b1;
         B_NUM_4:  r.num_4  = 1'b1;
         B_NUM_5:  r.num_5  = 1'b1;
         B_NUM_6:  r.num_6  = 1'b1;
         B_NUM_7:  r.num_7  = 1'b1;
         B_NUM_8:  r.num_8  = 1'b1;
         B_NUM_9:  r.num_9  = 1'b1;
         B_OP_ADD: r.op_add = 1'b1;
         B_OP_SUB: r.op_sub = 1'b1;
         B_OP_MUL: r.op_mul = 1'b1;
         B_OP_DIV: r.op_div = 1'b1;
         B_EQUALS: r.equals = 1'b1;
         B_CLEAR:  r.clear  = 1'b1;
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/button_fifo.sv
// button_fifo: circular queue of entries for the button sequencer.
//   clk_i/rst_ni : clock, synchronous active-low reset.
//   push_i/data_i: enqueue data_i (ignored while full or flushing).
//   pop_i        : dequeue head (ignored while empty or flushing).
//   flush_i      : empty the queue on the next edge.
//   full_o/empty_o/count_o : occupancy status; head_o : oldest entry.
module button_fifo #(
   parameter int unsigned Depth   = 8,
   parameter type         entry_t = logic [7:0]
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  entry_t                     data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth+1)-1:0] count_o,
   output entry_t                     head_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth+1);

   entry_t            mem_q [Depth];
   logic [PtrW-1:0]   wr_ptr_q;
   logic [PtrW-1:0]   rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/button_sequencer.sv
// button_sequencer: queues button requests and replays each one as a
// timed press (HoldCycles) followed by an all-released gap (GapCycles).
//   clk_i/rst_ni      : clock, synchronous active-low reset.
//   valid_i/button_i  : enqueue request; accepted when ready_o and !flush_i.
//   ready_o           : queue not full.
//   flush_i           : drop queue and abort the current press.
//   buttons_o         : registered one-hot button drive.
//   busy_o            : queue non-empty or sequencer active.
//   count_o           : queue occupancy.
//   done_o            : one-cycle pulse in the last gap cycle of each press.
module button_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned Depth      = 8,
   parameter int unsigned HoldCycles = 4,
   parameter int unsigned GapCycles  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       valid_i,
   input  active_button_t             button_i,
   output logic                       ready_o,
   input  logic                       flush_i,
   output buttons_t                   buttons_o,
   output logic                       busy_o,
   output logic [$clog2(Depth+1)-1:0] count_o,
   output logic                       done_o
);

   localparam int unsigned QW     = $clog2(Depth+1);
   localparam int unsigned MaxCyc = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
   localparam int unsigned CntW   = $clog2(MaxCyc+1);

   typedef enum logic [1:0] {IDLE, PRESS, GAP} state_e;

   state_e            state_q;
   logic [CntW-1:0]   hold_q;
   logic [CntW-1:0]   gap_q;
   buttons_t          buttons_q;
   logic              done_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic [QW-1:0]     fifo_count;
   active_button_t    head;
   logic              push;
   logic              pop;

   assign ready_o = !fifo_full;
   assign push    = valid_i && ready_o && !flush_i;
   assign pop     = !flush_i && !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == GAP) && (gap_q == '0)));

   button_fifo #(
      .Depth   (Depth),
      .entry_t (active_button_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (button_i),
      .pop_i   (pop),
      .flush_i (flush_i),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (head)
   );

   // done_q is registered one edge early so it is high exactly in the
   // GAP cycle whose counter reads zero.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         gap_q     <= '0;
         buttons_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  buttons_q <= active_button_to_buttons(head);
                  hold_q    <= CntW'(HoldCycles - 1);
                  state_q   <= PRESS;
               end
            end
            PRESS: begin
               if (hold_q == '0) begin
                  buttons_q <= '0;
                  gap_q     <= CntW'(GapCycles - 1);
                  done_q    <= (GapCycles == 32'd1);
                  state_q   <= GAP;
               end else begin
                  hold_q <= hold_q - CntW'(1);
               end
            end
            GAP: begin
               if (gap_q != '0) begin
                  gap_q  <= gap_q - CntW'(1);
                  done_q <= (gap_q == CntW'(1));
               end else if (pop) begin
                  buttons_q <= active_button_to_buttons(head);
                  hold_q    <= CntW'(HoldCycles - 1);
                  state_q   <= PRESS;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign buttons_o = buttons_q;
   assign done_o    = done_q;
   assign count_o   = fifo_count;
   assign busy_o    = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_button_sequencer.sv
// Directed bench for button_sequencer: table-driven vectors on a default
// instance plus hand-written sequences for the full queue and 1/1 timing.
package dv_pkg;
   import calc_pkg::*;
   function automatic buttons_t button2buttons(input active_button_t b);
      return active_button_to_buttons(b);
   endfunction
endpackage

module tb_button_sequencer;
   import calc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // default instance
   logic d_rst_n, d_valid, d_flush, d_ready, d_busy, d_done;
   active_button_t d_btn;
   buttons_t d_buttons;
   logic [3:0] d_count;
   // Depth=4 instance
   logic f_rst_n, f_valid, f_flush, f_ready, f_busy, f_done;
   active_button_t f_btn;
   buttons_t f_buttons;
   logic [2:0] f_count;
   // HoldCycles=1, GapCycles=1 instance
   logic s_rst_n, s_valid, s_flush, s_ready, s_busy, s_done;
   active_button_t s_btn;
   buttons_t s_buttons;
   logic [3:0] s_count;

   button_sequencer u_def (
      .clk_i(clk), .rst_ni(d_rst_n), .valid_i(d_valid), .button_i(d_btn),
      .ready_o(d_ready), .flush_i(d_flush), .buttons_o(d_buttons),
      .busy_o(d_busy), .count_o(d_count), .done_o(d_done));

   button_sequencer #(.Depth(4)) u_full (
      .clk_i(clk), .rst_ni(f_rst_n), .valid_i(f_valid), .button_i(f_btn),
      .ready_o(f_ready), .flush_i(f_flush), .buttons_o(f_buttons),
      .busy_o(f_busy), .count_o(f_count), .done_o(f_done));

   button_sequencer #(.HoldCycles(1), .GapCycles(1)) u_fast (
      .clk_i(clk), .rst_ni(s_rst_n), .valid_i(s_valid), .button_i(s_btn),
      .ready_o(s_ready), .flush_i(s_flush), .buttons_o(s_buttons),
      .busy_o(s_busy), .count_o(s_count), .done_o(s_done));

   typedef struct {
      logic           rst_n;
      logic           valid;
      active_button_t btn;
      logic           flush;
      buttons_t       e_btn;
      logic           e_done;
      logic           e_busy;
      int             e_count;
      logic           e_ready;
   } vec_t;

   vec_t vecs[$];

   buttons_t Z, bN0, bN1, bN2, bN3, bN4, bN7, bN9, bADD, bCLR;

   task automatic add(input int n, input logic rn, input logic v,
                      input active_button_t b, input logic fl, input buttons_t eb,
                      input logic ed, input logic ebz, input int ec, input logic er);
      vec_t r;
      r.rst_n = rn; r.valid = v; r.btn = b; r.flush = fl;
      r.e_btn = eb; r.e_done = ed; r.e_busy = ebz; r.e_count = ec; r.e_ready = er;
      for (int i = 0; i < n; i++) vecs.push_back(r);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      buttons_t seen[$];
      buttons_t exp_full[4];
      buttons_t prev;

      Z = '0;
      bN0 = '0;  bN0.num_0  = 1'b1;
      bN1 = '0;  bN1.num_1  = 1'b1;
      bN2 = '0;  bN2.num_2  = 1'b1;
      bN3 = '0;  bN3.num_3  = 1'b1;
      bN4 = '0;  bN4.num_4  = 1'b1;
      bN7 = '0;  bN7.num_7  = 1'b1;
      bN9 = '0;  bN9.num_9  = 1'b1;
      bADD = '0; bADD.op_add = 1'b1;
      bCLR = '0; bCLR.clear  = 1'b1;
      exp_full[0] = bN1; exp_full[1] = bN2; exp_full[2] = bN3; exp_full[3] = bN4;

      // single press: push B_NUM_7 in cycle 10
      add(10, 1, 0, B_NONE,  0, Z,   0, 0, 0, 1);
      add(1,  1, 1, B_NUM_7, 0, Z,   0, 0, 0, 1);
      add(1,  1, 0, B_NONE,  0, Z,   0, 1, 1, 1);
      add(4,  1, 0, B_NONE,  0, bN7, 0, 1, 0, 1);
      add(3,  1, 0, B_NONE,  0, Z,   0, 1, 0, 1);
      add(1,  1, 0, B_NONE,  0, Z,   1, 1, 0, 1);
      add(2,  1, 0, B_NONE,  0, Z,   0, 0, 0, 1);
      // back-to-back 1,2,3
      add(1,  1, 1, B_NUM_1, 0, Z,   0, 0, 0, 1);
      add(1,  1, 1, B_NUM_2, 0, Z,   0, 1, 1, 1);
      add(1,  1, 1, B_NUM_3, 0, bN1, 0, 1, 1, 1);
      add(3,  1, 0, B_NONE,  0, bN1, 0, 1, 2, 1);
      add(3,  1, 0, B_NONE,  0, Z,   0, 1, 2, 1);
      add(1,  1, 0, B_NONE,  0, Z,   1, 1, 2, 1);
      add(4,  1, 0, B_NONE,  0, bN2, 0, 1, 1, 1);
      add(3,  1, 0, B_NONE,  0, Z,   0, 1, 1, 1);
      add(1,  1, 0, B_NONE,  0, Z,   1, 1, 1, 1);
      add(4,  1, 0, B_NONE,  0, bN3, 0, 1, 0, 1);
      add(3,  1, 0, B_NONE,  0, Z,   0, 1, 0, 1);
      add(1,  1, 0, B_NONE,  0, Z,   1, 1, 0, 1);
      add(2,  1, 0, B_NONE,  0, Z,   0, 0, 0, 1);
      // flush in 2nd hold cycle of B_OP_ADD with 3 queued, push dropped
      add(1,  1, 1, B_NUM_9, 0, Z,   0, 0, 0, 1);
      add(1,  1, 1, B_OP_ADD,0, Z,   0, 1, 1, 1);
      add(1,  1, 1, B_NUM_4, 0, bN9, 0, 1, 1, 1);
      add(1,  1, 1, B_NUM_5, 0, bN9, 0, 1, 2, 1);
      add(1,  1, 1, B_NUM_6, 0, bN9, 0, 1, 3, 1);
      add(1,  1, 0, B_NONE,  0, bN9, 0, 1, 4, 1);
      add(3,  1, 0, B_NONE,  0, Z,   0, 1, 4, 1);
      add(1,  1, 0, B_NONE,  0, Z,   1, 1, 4, 1);
      add(1,  1, 0, B_NONE,  0, bADD,0, 1, 3, 1);
      add(1,  1, 1, B_NUM_8, 1, bADD,0, 1, 3, 1);
      add(10, 1, 0, B_NONE,  0, Z,   0, 0, 0, 1);
      // reset for one cycle during GAP with 2 queued
      add(1,  1, 1, B_NUM_1, 0, Z,   0, 0, 0, 1);
      add(1,  1, 1, B_NUM_2, 0, Z,   0, 1, 1, 1);
      add(1,  1, 1, B_NUM_3, 0, bN1, 0, 1, 1, 1);
      add(3,  1, 0, B_NONE,  0, bN1, 0, 1, 2, 1);
      add(1,  1, 0, B_NONE,  0, Z,   0, 1, 2, 1);
      add(1,  0, 0, B_NONE,  0, Z,   0, 1, 2, 1);
      add(20, 1, 0, B_NONE,  0, Z,   0, 0, 0, 1);

      d_rst_n = 0; d_valid = 0; d_btn = B_NONE; d_flush = 0;
      f_rst_n = 0; f_valid = 0; f_btn = B_NONE; f_flush = 0;
      s_rst_n = 0; s_valid = 0; s_btn = B_NONE; s_flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset buttons", 32'(d_buttons), 32'h0);
      chk("reset done",    32'(d_done),    32'h0);
      chk("reset busy",    32'(d_busy),    32'h0);
      chk("reset count",   32'(d_count),   32'h0);
      chk("reset ready",   32'(d_ready),   32'h1);
      chk("reset full count", 32'(f_count), 32'h0);
      chk("reset fast busy",  32'(s_busy),  32'h0);
      f_rst_n = 1; s_rst_n = 1;

      // table: check outputs for this cycle, then drive this cycle's inputs
      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         chk($sformatf("row%0d buttons", i), 32'(d_buttons), 32'(vecs[i].e_btn));
         chk($sformatf("row%0d done", i),    32'(d_done),    32'(vecs[i].e_done));
         chk($sformatf("row%0d busy", i),    32'(d_busy),    32'(vecs[i].e_busy));
         chk($sformatf("row%0d count", i),   32'(d_count),   32'(vecs[i].e_count));
         chk($sformatf("row%0d ready", i),   32'(d_ready),   32'(vecs[i].e_ready));
         d_rst_n = vecs[i].rst_n; d_valid = vecs[i].valid;
         d_btn   = vecs[i].btn;   d_flush = vecs[i].flush;
      end
      @(negedge clk);
      d_valid = 0; d_flush = 0;

      // full queue, Depth=4: 6 pushes during a press, then a push at full+pop
      f_valid = 1; f_btn = B_NUM_0;
      @(negedge clk); chk("full s1 count", 32'(f_count), 32'd1); f_valid = 0;
      @(negedge clk); chk("full s2 press", 32'(f_buttons), 32'(bN0));
      f_valid = 1; f_btn = B_NUM_1;
      @(negedge clk); f_btn = B_NUM_2;
      @(negedge clk); f_btn = B_NUM_3;
      @(negedge clk); f_btn = B_NUM_4;
      @(negedge clk);
      chk("full s6 count", 32'(f_count), 32'd4);
      chk("full s6 ready", 32'(f_ready), 32'd0);
      f_btn = B_NUM_5;
      @(negedge clk); f_btn = B_NUM_6;
      @(negedge clk); f_valid = 0;
      chk("full s8 count", 32'(f_count), 32'd4);
      chk("full s8 ready", 32'(f_ready), 32'd0);
      @(negedge clk);
      chk("full s9 done",  32'(f_done),  32'd1);
      chk("full s9 count", 32'(f_count), 32'd4);
      f_valid = 1; f_btn = B_NUM_7;
      @(negedge clk); f_valid = 0;
      chk("full s10 count", 32'(f_count), 32'd3);
      chk("full s10 ready", 32'(f_ready), 32'd1);
      prev = '0;
      for (int c = 0; c < 50; c++) begin
         if (c != 0) @(negedge clk);
         if (f_buttons != '0 && prev == '0) seen.push_back(f_buttons);
         prev = f_buttons;
      end
      chk("full press count", 32'(seen.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < seen.size())
            chk($sformatf("full press%0d", k), 32'(seen[k]), 32'(exp_full[k]));
         else
            chk($sformatf("full press%0d", k), 32'hdead, 32'(exp_full[k]));
      end
      chk("full end busy", 32'(f_busy), 32'd0);

      // HoldCycles=1, GapCycles=1: B_NONE pause then B_CLEAR
      @(negedge clk);
      s_valid = 1; s_btn = B_NONE;
      @(negedge clk);
      chk("fast t1 count", 32'(s_count), 32'd1);
      s_btn = B_CLEAR;
      @(negedge clk); s_valid = 0;
      chk("fast t2 buttons", 32'(s_buttons), 32'h0);
      chk("fast t2 busy",    32'(s_busy),    32'd1);
      chk("fast t2 done",    32'(s_done),    32'd0);
      @(negedge clk);
      chk("fast t3 buttons", 32'(s_buttons), 32'h0);
      chk("fast t3 done",    32'(s_done),    32'd1);
      @(negedge clk);
      chk("fast t4 buttons", 32'(s_buttons), 32'(bCLR));
      chk("fast t4 done",    32'(s_done),    32'd0);
      chk("fast t4 count",   32'(s_count),   32'd0);
      @(negedge clk);
      chk("fast t5 buttons", 32'(s_buttons), 32'h0);
      chk("fast t5 done",    32'(s_done),    32'd1);
      @(negedge clk);
      chk("fast t6 busy",    32'(s_busy),    32'd0);
      chk("fast t6 done",    32'(s_done),    32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
